// File: rtl/nibble_serial_cla_adder.sv
// Word-serial adder built around one 4-bit carry-lookahead slice.
// Adds one nibble per clock, so a WIDTH-bit add takes WIDTH/4 cycles.
module nibble_serial_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  ra;
    logic [WIDTH-1:0]  rb;
    logic [WIDTH-5:0]  acc;
    logic              cr;
    logic [KW-1:0]     k;

    logic [3:0]        g;
    logic [3:0]        p;
    logic [3:0]        c;
    logic [3:0]        pn;
    logic [WIDTH-1:0]  acc_sh;

    // Lookahead on the low nibble of the shifting operands.
    always_comb begin
        g = ra[3:0] & rb[3:0];
        p = ra[3:0] ^ rb[3:0];
        c[0] = g[0] | (p[0] & cr);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cr);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cr);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cr);
        pn = p ^ {c[2:0], cr};
        // New nibble enters at the top; after NIB steps nibble 0 is at the bottom.
        acc_sh = {pn, acc};
    end

    // Control FSM, operand shifters, accumulator and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            cr    <= 1'b0;
            k     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        cr    <= cin;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    ra  <= ra >> 4;
                    rb  <= rb >> 4;
                    acc <= acc_sh[WIDTH-1:4];
                    cr  <= c[3];
                    k   <= k + KW'(1);
                    if (k == KW'(NIB - 1)) begin
                        sum   <= acc_sh;
                        cout  <= c[3];
                        ovf   <= c[3] ^ c[2];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        k     <= '0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Directed and random checks for the nibble-serial CLA adder,
// at WIDTH=16 and WIDTH=32.
module tb_nibble_serial_cla_adder;

    logic        clk;
    logic        rst;

    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        start32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        cin32;
    logic        busy32;
    logic        done32;
    logic [31:0] sum32;
    logic        cout32;
    logic        ovf32;

    int errs;
    int checks;
    int lat;

    nibble_serial_cla_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    nibble_serial_cla_adder #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .start (start32),
        .a     (a32),
        .b     (b32),
        .cin   (cin32),
        .busy  (busy32),
        .done  (done32),
        .sum   (sum32),
        .cout  (cout32),
        .ovf   (ovf32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; the next edge is the accepting edge E0.
    task automatic go16(input logic [15:0] va, input logic [15:0] vb,
                        input logic vc);
        start = 1'b1;
        a     = va;
        b     = vb;
        cin   = vc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait16(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic go32(input logic [31:0] va, input logic [31:0] vb,
                        input logic vc);
        start32 = 1'b1;
        a32     = va;
        b32     = vb;
        cin32   = vc;
        @(posedge clk);
        #1;
        start32 = 1'b0;
    endtask

    task automatic wait32(output int n);
        n = 0;
        while (done32 !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        logic [15:0] ra16;
        logic [15:0] rb16;
        logic        rc16;
        logic [16:0] ref16;
        logic        rov16;
        logic [31:0] ra32;
        logic [31:0] rb32;
        logic        rc32;
        logic [32:0] ref32;
        logic        rov32;

        errs    = 0;
        checks  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        start32 = 1'b0;
        a32     = '0;
        b32     = '0;
        cin32   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // FFFF + 0001 wraps to zero with carry out
        go16(16'hFFFF, 16'h0001, 1'b0);
        chk("t1_busy", 64'(busy), 64'd1);
        wait16(lat);
        chk("t1_lat",  64'(lat),  64'd4);
        chk("t1_sum",  64'(sum),  64'h0000);
        chk("t1_cout", 64'(cout), 64'd1);
        chk("t1_ovf",  64'(ovf),  64'd0);
        chk("t1_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("t1_pulse", 64'(done), 64'd0);

        // 7FFF + 1 overflows into the sign bit
        go16(16'h7FFF, 16'h0001, 1'b0);
        wait16(lat);
        chk("t2_lat",  64'(lat),  64'd4);
        chk("t2_sum",  64'(sum),  64'h8000);
        chk("t2_cout", 64'(cout), 64'd0);
        chk("t2_ovf",  64'(ovf),  64'd1);

        // 1234 + 4321 + 1, previous result must hold during the add
        go16(16'h1234, 16'h4321, 1'b1);
        chk("t3_hold_sum", 64'(sum), 64'h8000);
        @(posedge clk);
        #1;
        chk("t3_hold_sum2", 64'(sum), 64'h8000);
        chk("t3_hold_ovf",  64'(ovf), 64'd1);
        wait16(lat);
        chk("t3_lat",  64'(lat),  64'd3);
        chk("t3_sum",  64'(sum),  64'h5556);
        chk("t3_cout", 64'(cout), 64'd0);
        chk("t3_ovf",  64'(ovf),  64'd0);

        // start while busy is ignored; start in the done cycle is taken
        go16(16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            a     = 16'hFFFF;
            b     = 16'hFFFF;
            cin   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_sum",  64'(sum),  64'h3333);
        chk("t4_cout", 64'(cout), 64'd0);
        go16(16'h0F0F, 16'h00F1, 1'b0);
        chk("t4_b2b_busy", 64'(busy), 64'd1);
        chk("t4_b2b_done", 64'(done), 64'd0);
        wait16(lat);
        chk("t4_b2b_lat", 64'(lat), 64'd4);
        chk("t4_b2b_sum", 64'(sum), 64'h1000);
        @(posedge clk);
        #1;
        chk("t4_no_extra", 64'(done), 64'd0);

        // async reset mid-add abandons it
        go16(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_sum",  64'(sum),  64'd0);
        chk("t5_cout", 64'(cout), 64'd0);
        chk("t5_ovf",  64'(ovf),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("t5_no_done", 64'(done), 64'd0);
        end
        go16(16'h8000, 16'h8000, 1'b1);
        wait16(lat);
        chk("t5_lat",  64'(lat),  64'd4);
        chk("t5_sum",  64'(sum),  64'h0001);
        chk("t5_cout", 64'(cout), 64'd1);
        chk("t5_ovf",  64'(ovf),  64'd1);

        // random adds, WIDTH=16
        for (int i = 0; i < 2000; i++) begin
            ra16  = 16'($urandom);
            rb16  = 16'($urandom);
            rc16  = 1'($urandom);
            ref16 = {1'b0, ra16} + {1'b0, rb16} + {16'd0, rc16};
            rov16 = (ra16[15] == rb16[15]) && (ref16[15] != ra16[15]);
            go16(ra16, rb16, rc16);
            wait16(lat);
            chk("r16_lat", 64'(lat), 64'd4);
            chk("r16_sum", 64'({cout, sum}), 64'(ref16));
            chk("r16_ovf", 64'(ovf), 64'(rov16));
        end

        // random adds, WIDTH=32
        for (int i = 0; i < 2000; i++) begin
            ra32  = $urandom;
            rb32  = $urandom;
            rc32  = 1'($urandom);
            ref32 = {1'b0, ra32} + {1'b0, rb32} + {32'd0, rc32};
            rov32 = (ra32[31] == rb32[31]) && (ref32[31] != ra32[31]);
            go32(ra32, rb32, rc32);
            wait32(lat);
            chk("r32_lat", 64'(lat), 64'd8);
            chk("r32_sum", 64'({cout32, sum32}), 64'(ref32));
            chk("r32_ovf", 64'(ovf32), 64'(rov32));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
